// File: rtl/fsm_pkg.sv
// Shared types and entry helpers for the table-driven Mealy FSM.
// A table entry is {next_state, out}, with next_state in the upper bits.
package fsm_pkg;

  localparam int FIELD_W = 32;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_ADVANCE,
    STEP_RECOVER
  } step_e;

  function automatic int entry_w(int sw, int out_w);
    return sw + out_w;
  endfunction

  function automatic logic [FIELD_W-1:0] out_mask(int out_w);
    return (FIELD_W'(1) << out_w) - FIELD_W'(1);
  endfunction

  function automatic logic [FIELD_W-1:0] pack_entry(logic [FIELD_W-1:0] nxt,
                                                    logic [FIELD_W-1:0] out,
                                                    int out_w);
    return (nxt << out_w) | (out & out_mask(out_w));
  endfunction

  function automatic logic [FIELD_W-1:0] unpack_next(logic [FIELD_W-1:0] e, int out_w);
    return e >> out_w;
  endfunction

  function automatic logic [FIELD_W-1:0] unpack_out(logic [FIELD_W-1:0] e, int out_w);
    return e & out_mask(out_w);
  endfunction

  // State encodings at or above num_states are illegal.
  function automatic logic state_in_range(logic [FIELD_W-1:0] s, int num_states);
    return s < FIELD_W'(num_states);
  endfunction

endpackage

// File: rtl/fsm_table_ram.sv
// Transition/output table: synchronous write, synchronous reset to a fixed entry,
// asynchronous read. Reads beyond the populated depth return zero.
module fsm_table_ram #(
  parameter int            DEPTH     = 10,
  parameter int            AW        = 4,
  parameter int            EW        = 4,
  parameter logic [EW-1:0] RST_ENTRY = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_ENTRY;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < DEPTH_L) ? mem[raddr] : '0;

endmodule

// File: rtl/prog_mealy_fsm.sv
// Run-time programmable Mealy FSM: state register, range checks, sticky error
// flag and an optional registered output around a {state, x}-indexed table.
//
// step mode    | meaning
// STEP_HOLD    | en=0, state holds
// STEP_ADVANCE | en=1, legal state and legal next: take table next
// STEP_RECOVER | en=1, illegal state or next: go to RESET_STATE, flag err
module prog_mealy_fsm
  import fsm_pkg::*;
#(
  parameter  int NUM_STATES  = 5,
  parameter  int IN_W        = 1,
  parameter  int OUT_W       = 1,
  parameter  int RESET_STATE = 0,
  parameter  int OUT_REG     = 0,
  localparam int SW          = $clog2(NUM_STATES),
  localparam int AW          = SW + IN_W,
  localparam int EW          = entry_w(SW, OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y,
  output logic [SW-1:0]    state_o,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [EW-1:0]    cfg_data,
  output logic             err,
  input  logic             err_clr
);

  localparam int            DEPTH     = NUM_STATES * (2 ** IN_W);
  localparam logic [SW-1:0] RST_STATE = SW'(RESET_STATE);
  localparam logic [EW-1:0] RST_ENTRY = EW'(pack_entry(FIELD_W'(RESET_STATE), '0, OUT_W));

  logic [SW-1:0]      state, state_d;
  logic [EW-1:0]      rd_entry;
  logic [FIELD_W-1:0] nxt_full;
  logic [SW-1:0]      e_next;
  logic [OUT_W-1:0]   e_out;
  logic               cur_legal, nxt_legal, addr_legal;
  logic               err_set;
  step_e              step;

  fsm_table_ram #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .EW        (EW),
    .RST_ENTRY (RST_ENTRY)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we && addr_legal),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr ({state, x}),
    .rdata (rd_entry)
  );

  assign cur_legal  = state_in_range(FIELD_W'(state), NUM_STATES);
  assign addr_legal = state_in_range(FIELD_W'(cfg_addr) >> IN_W, NUM_STATES);
  assign nxt_full   = unpack_next(FIELD_W'(rd_entry), OUT_W);
  assign nxt_legal  = state_in_range(nxt_full, NUM_STATES);
  assign e_next     = SW'(nxt_full);
  // An upset state must not leak a stale table output.
  assign e_out      = cur_legal ? OUT_W'(unpack_out(FIELD_W'(rd_entry), OUT_W)) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_d;
  end

  always_comb begin
    step    = STEP_HOLD;
    state_d = state;
    err_set = cfg_we && !addr_legal;
    if (en) begin
      if (cur_legal && nxt_legal) step = STEP_ADVANCE;
      else                        step = STEP_RECOVER;
    end
    case (step)
      STEP_ADVANCE: state_d = e_next;
      STEP_RECOVER: begin
        state_d = RST_STATE;
        err_set = 1'b1;
      end
      default: state_d = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [OUT_W-1:0] y_q;
      always_ff @(posedge clk) begin
        if (rst)     y_q <= '0;
        else if (en) y_q <= e_out;
      end
      assign y = y_q;
    end else begin : g_out_comb
      assign y = e_out;
    end
  endgenerate

  assign state_o = state;

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Bench for prog_mealy_fsm: combinational and registered-output instances share
// one stimulus stream and one table-level model, plus directed literal checks.
module tb_prog_mealy_fsm;

  logic       clk = 1'b0;
  logic       rst, en, x, cfg_we, err_clr;
  logic [3:0] cfg_addr, cfg_data;
  logic       y0, y1, err0, err1;
  logic [2:0] st0, st1;

  always #5 clk = ~clk;

  prog_mealy_fsm #(.NUM_STATES(5), .IN_W(1), .OUT_W(1), .RESET_STATE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y0), .state_o(st0),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .err(err0), .err_clr(err_clr));

  prog_mealy_fsm #(.NUM_STATES(5), .IN_W(1), .OUT_W(1), .RESET_STATE(0), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y1), .state_o(st1),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .err(err1), .err_clr(err_clr));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Model: table as plain arrays indexed by state*2 + x; illegal next coded as >= 5.
  int m_next[10];
  int m_out[10];
  int m_state, m_yreg, m_err;

  task automatic chk(string name, logic [31:0] act, int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lk_next();
    return (m_state < 5) ? m_next[m_state * 2 + int'(x)] : 99;
  endfunction

  function automatic int lk_out();
    return (m_state < 5) ? m_out[m_state * 2 + int'(x)] : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0;
      m_yreg  <= 0;
      m_err   <= 0;
      for (int i = 0; i < 10; i++) begin
        m_next[i] <= 0;
        m_out[i]  <= 0;
      end
    end else begin
      if (en) begin
        m_yreg  <= lk_out();
        m_state <= (lk_next() < 5) ? lk_next() : 0;
      end
      if (cfg_we && int'(cfg_addr) < 10) begin
        m_next[int'(cfg_addr)] <= int'(cfg_data) / 2;
        m_out[int'(cfg_addr)]  <= int'(cfg_data) % 2;
      end
      if ((en && lk_next() >= 5) || (cfg_we && int'(cfg_addr) >= 10)) m_err <= 1;
      else if (err_clr)                                             m_err <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state_comb", st0, m_state);
      chk("state_reg", st1, m_state);
      chk("y_comb", y0, lk_out());
      chk("y_reg", y1, m_yreg);
      chk("err_comb", err0, m_err);
      chk("err_reg", err1, m_err);
    end
  end

  task automatic set_in(bit r, bit e, bit xi, bit we = 1'b0, logic [3:0] a = 4'd0,
                        logic [3:0] d = 4'd0, bit clr = 1'b0);
    rst = r; en = e; x = xi; cfg_we = we; cfg_addr = a; cfg_data = d; err_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int load_tab[10] = '{6, 9, 2, 9, 4, 1, 2, 5, 4, 6};
  int seq_x[6]     = '{0, 1, 1, 0, 0, 1};
  int exp_s[7]     = '{0, 3, 2, 0, 3, 1, 4};
  int exp_y[6]     = '{0, 1, 1, 0, 0, 1};

  initial begin
    // Reset values
    set_in(1, 0, 0);
    tick(); tick();
    chk_on = 1'b1;
    set_in(0, 1, 1);
    #2;
    chk("rst_state", st0, 0); chk("rst_y_comb", y0, 0); chk("rst_y_reg", y1, 0); chk("rst_err", err0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_tbl_state%0d", i), st0, 0);
      chk($sformatf("rst_tbl_y%0d", i), y1, 0);
    end

    // Sequence table load and run
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 1, 4'(i), 4'(load_tab[i]));
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, 1'(seq_x[i]));
      #2;
      chk($sformatf("seq_state%0d", i), st0, exp_s[i]);
      chk($sformatf("seq_y_comb%0d", i), y0, exp_y[i]);
      chk($sformatf("seq_y_reg%0d", i), y1, (i == 0) ? 0 : exp_y[i-1]);
      tick();
    end
    chk("seq_state_end", st0, exp_s[6]);
    chk("seq_y_reg_end", y1, exp_y[5]);

    // en gating in state 3
    set_in(0, 1, 1); tick();
    chk("gate_enter", st0, 3);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 1'(i % 2));
      #2;
      chk($sformatf("gate_state%0d", i), st0, 3);
      chk($sformatf("gate_y_comb%0d", i), y0, i % 2);
      chk($sformatf("gate_y_reg%0d", i), y1, 0);
      tick();
    end

    // Illegal next state, err clear, bad cfg address, set-vs-clear priority
    set_in(0, 1, 1); tick();
    set_in(0, 1, 1); tick();
    chk("ill_at_s0", st0, 0);
    set_in(0, 0, 0, 1, 4'd1, 4'hF); tick();
    set_in(0, 1, 1);
    #2;
    chk("ill_y_comb", y0, 1);
    tick();
    chk("ill_state", st0, 0); chk("ill_err", err0, 1); chk("ill_y_reg", y1, 1);
    set_in(0, 0, 0); tick();
    chk("ill_err_hold", err0, 1);
    set_in(0, 0, 0, 0, 4'd0, 4'd0, 1); tick();
    chk("ill_err_clr", err0, 0);
    set_in(0, 0, 0, 1, 4'd10, 4'd0); tick();
    chk("badaddr_err", err0, 1);
    set_in(0, 0, 0, 1, 4'd11, 4'd0, 1); tick();
    chk("set_wins", err1, 1);
    set_in(0, 0, 0, 0, 4'd0, 4'd0, 1); tick();
    chk("clr_after", err1, 0);

    // Write/step collision: step uses old entry
    set_in(0, 1, 0); tick();
    set_in(0, 1, 1); tick();
    chk("col_at_s2", st0, 2);
    set_in(0, 1, 1, 1, 4'd5, 4'd2); tick();
    chk("col_old_entry", st0, 0); chk("col_old_y", y1, 1);
    set_in(0, 1, 0); tick();
    set_in(0, 1, 1); tick();
    chk("col_back_s2", st0, 2);
    set_in(0, 1, 1); tick();
    chk("col_new_entry", st0, 1); chk("col_new_y", y1, 0);

    // Reset mid-run clears the table and beats a concurrent write
    set_in(1, 1, 1, 1, 4'd0, 4'hF, 1); tick();
    set_in(0, 1, 0);
    #2;
    chk("mrst_state", st0, 0); chk("mrst_y_comb", y0, 0); chk("mrst_y_reg", y1, 0); chk("mrst_err", err0, 0);
    tick();
    chk("mrst_tbl_x0", st0, 0);
    set_in(0, 1, 1); tick();
    chk("mrst_tbl_x1", st0, 0); chk("mrst_tbl_y", y1, 0); chk("mrst_tbl_err", err0, 0);

    set_in(0, 0, 0);
    tick();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
